axi_stream_strip_header: RTL



---
 rtl/axi_stream_strip_header.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi_stream_strip_header.sv
// Strips a 1..DATA_BYTE_WD byte header from the front of an AXI-Stream packet,
// presents it on a separate port, and realigns the payload MSB-first.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, FLUSH} state_t;

  state_t                  state;
  logic [BYTE_CNT_WD:0]    hlen;
  logic [BYTE_CNT_WD:0]    res_len;
  logic [BYTE_CNT_WD+3:0]  hlen_bits;
  logic [BYTE_CNT_WD+3:0]  res_bits;
  logic [DATA_WD-1:0]      res_data;
  logic [DATA_BYTE_WD-1:0] res_keep;
  logic [DATA_WD-1:0]      data_masked;
  logic [DATA_WD-1:0]      head_data;
  logic [DATA_BYTE_WD-1:0] head_keep;
  logic [DATA_WD-1:0]      tail_data;
  logic [DATA_BYTE_WD-1:0] tail_keep;
  logic                    out_free;
  logic                    hdr_free;
  logic                    in_fire;

  always_comb begin
    data_masked = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      data_masked[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
    end
  end

  // head_* are the first H bytes of the beat, right-aligned; tail_* are the
  // remaining W-H bytes, left-aligned so they can prefix the next beat.
  always_comb begin
    res_len   = (BYTE_CNT_WD+1)'(DATA_BYTE_WD) - hlen;
    hlen_bits = {hlen, 3'b000};
    res_bits  = {res_len, 3'b000};
    head_data = data_masked >> res_bits;
    head_keep = keep_in >> res_len;
    tail_data = data_masked << hlen_bits;
    tail_keep = keep_in << hlen;
  end

  assign out_free    = !valid_out || ready_out;
  assign hdr_free    = !valid_header || ready_header;
  assign ready_strip = (state == IDLE);
  assign ready_in    = ((state == HEAD) && hdr_free && out_free) ||
                       ((state == BODY) && out_free);
  assign in_fire     = valid_in && ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hlen         <= '0;
      res_data     <= '0;
      res_keep     <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
    end else begin
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (valid_header && ready_header) valid_header <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_strip) begin
            hlen  <= {1'b0, byte_strip_cnt} + 1'b1;
            state <= HEAD;
          end
        end

        HEAD: begin
          if (in_fire) begin
            valid_header <= 1'b1;
            data_header  <= head_data;
            keep_header  <= head_keep;
            res_data     <= tail_data;
            res_keep     <= tail_keep;
            if (last_in) begin
              // Single-beat packet: whatever follows the header is the payload.
              if (|tail_keep) begin
                valid_out <= 1'b1;
                data_out  <= tail_data;
                keep_out  <= tail_keep;
                last_out  <= 1'b1;
              end
              state <= IDLE;
            end else begin
              state <= BODY;
            end
          end
        end

        BODY: begin
          if (in_fire) begin
            valid_out <= 1'b1;
            data_out  <= res_data | head_data;
            keep_out  <= res_keep | head_keep;
            res_data  <= tail_data;
            res_keep  <= tail_keep;
            if (last_in && (|tail_keep)) begin
              last_out <= 1'b0;
              state    <= FLUSH;
            end else if (last_in) begin
              last_out <= 1'b1;
              state    <= IDLE;
            end else begin
              last_out <= 1'b0;
            end
          end
        end

        FLUSH: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= res_data;
            keep_out  <= res_keep;
            last_out  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
